// File: rtl/alu_vector_sequencer.sv
// ALU self-test sequencer: walks NVEC ROM vectors through an external ALU, writes each
// result to RAM over a wen/ready handshake and optionally counts mismatches against vec_exp.
module alu_vector_sequencer #(
  parameter int             DW          = 32,
  parameter int             NVEC        = 16,
  parameter int             AW          = 32,
  parameter logic [AW-1:0]  ADDR_BASE   = {AW{1'b0}},
  parameter int             ADDR_STRIDE = 4,
  parameter int             CHECK_EN    = 1,
  localparam int            IW          = (NVEC > 1) ? $clog2(NVEC) : 1,
  localparam int            EW          = $clog2(NVEC + 1)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          start,
  output logic [IW-1:0] vec_idx,
  input  logic [DW-1:0] vec_a,
  input  logic [DW-1:0] vec_b,
  input  logic [3:0]    vec_op,
  input  logic [DW-1:0] vec_exp,
  input  logic          vec_chk,
  output logic [DW-1:0] alu_porta,
  output logic [DW-1:0] alu_portb,
  output logic [3:0]    alu_op,
  input  logic [DW-1:0] alu_out,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_store,
  output logic          mem_wen,
  input  logic          mem_ready,
  output logic          busy,
  output logic          halt,
  output logic [EW-1:0] err_count,
  output logic [IW-1:0] first_err
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ISSUE = 3'd1;
  localparam logic [2:0] WRITE = 3'd2;
  localparam logic [2:0] NEXT  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam logic [IW-1:0] LAST_IDX = IW'(NVEC - 1);
  localparam logic [EW-1:0] ERR_MAX  = EW'(NVEC);

  logic [2:0]    state_r;
  logic [2:0]    state_nx_s;
  logic [IW-1:0] idx_r;
  logic [DW-1:0] res_r;
  logic [DW-1:0] exp_r;
  logic          chk_r;
  logic [EW-1:0] err_count_r;
  logic [IW-1:0] first_err_r;
  logic          busy_r;
  logic          halt_r;
  logic          mem_wen_r;
  logic [AW-1:0] mem_addr_r;
  logic [DW-1:0] mem_store_r;

  // Byte address of result word idx; arithmetic is modulo 2^AW so the sequence wraps.
  function automatic logic [AW-1:0] addr_of(input logic [IW-1:0] idx);
    return ADDR_BASE + (AW'(idx) * AW'(ADDR_STRIDE));
  endfunction

  function automatic logic is_mismatch(input logic chk, input logic [DW-1:0] res,
                                       input logic [DW-1:0] exp);
    return chk && (res != exp);
  endfunction

  // Next-state decode.
  always_comb begin
    state_nx_s = IDLE;
    case (state_r)
      IDLE:    state_nx_s = start ? ISSUE : IDLE;
      ISSUE:   state_nx_s = WRITE;
      WRITE:   state_nx_s = mem_ready ? NEXT : WRITE;
      NEXT:    state_nx_s = (idx_r == LAST_IDX) ? DONE : ISSUE;
      DONE:    state_nx_s = start ? ISSUE : DONE;
      default: state_nx_s = IDLE;
    endcase
  end

  // State, vector index, captured result and error bookkeeping.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r     <= IDLE;
      idx_r       <= {IW{1'b0}};
      res_r       <= {DW{1'b0}};
      exp_r       <= {DW{1'b0}};
      chk_r       <= 1'b0;
      err_count_r <= {EW{1'b0}};
      first_err_r <= {IW{1'b0}};
    end else begin
      state_r <= state_nx_s;
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            idx_r       <= {IW{1'b0}};
            err_count_r <= {EW{1'b0}};
            first_err_r <= {IW{1'b0}};
          end
        end
        ISSUE: begin
          res_r <= alu_out;
          exp_r <= vec_exp;
          chk_r <= vec_chk & (CHECK_EN != 0);
        end
        WRITE: begin
          // Evaluated on the accepting cycle so a stalled write is counted once.
          if (mem_ready && is_mismatch(chk_r, res_r, exp_r)) begin
            if (err_count_r != ERR_MAX) begin
              err_count_r <= err_count_r + EW'(1);
            end
            if (err_count_r == {EW{1'b0}}) begin
              first_err_r <= idx_r;
            end
          end
        end
        NEXT: begin
          if (idx_r != LAST_IDX) begin
            idx_r <= idx_r + IW'(1);
          end
        end
        default: begin
          idx_r <= idx_r;
        end
      endcase
    end
  end

  // Registered handshake and status outputs, decoded from the upcoming state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      busy_r      <= 1'b0;
      halt_r      <= 1'b0;
      mem_wen_r   <= 1'b0;
      mem_addr_r  <= {AW{1'b0}};
      mem_store_r <= {DW{1'b0}};
    end else begin
      busy_r    <= (state_nx_s == ISSUE) || (state_nx_s == WRITE) || (state_nx_s == NEXT);
      halt_r    <= (state_nx_s == DONE);
      mem_wen_r <= (state_nx_s == WRITE);
      if (state_nx_s == WRITE) begin
        if (state_r == ISSUE) begin
          mem_addr_r  <= addr_of(idx_r);
          mem_store_r <= alu_out;
        end else begin
          mem_addr_r  <= mem_addr_r;
          mem_store_r <= mem_store_r;
        end
      end else begin
        mem_addr_r  <= {AW{1'b0}};
        mem_store_r <= {DW{1'b0}};
      end
    end
  end

  // The ROM and ALU are combinational, so operands are presented during ISSUE itself.
  always_comb begin
    if (state_r == ISSUE) begin
      alu_porta = vec_a;
      alu_portb = vec_b;
      alu_op    = vec_op;
    end else begin
      alu_porta = {DW{1'b0}};
      alu_portb = {DW{1'b0}};
      alu_op    = 4'd0;
    end
  end

  assign vec_idx   = idx_r;
  assign busy      = busy_r;
  assign halt      = halt_r;
  assign mem_wen   = mem_wen_r;
  assign mem_addr  = mem_addr_r;
  assign mem_store = mem_store_r;
  assign err_count = err_count_r;
  assign first_err = first_err_r;

endmodule

// File: tb/tb_alu_vector_sequencer.sv
// Scoreboard bench for alu_vector_sequencer: the bench plays ROM and ALU, queues expected
// RAM writes at stimulus time and monitors pop/compare on every accepted write.
module tb_alu_vector_sequencer;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  logic [31:0] a_tab [4] = '{32'd5, 32'd10, 32'h0000_F0F0, 32'h0000_00F0};
  logic [31:0] b_tab [4] = '{32'd3, 32'd4, 32'h0000_FF00, 32'h0000_000F};
  logic [3:0]  op_tab[4] = '{4'd0, 4'd1, 4'd2, 4'd3};
  logic [31:0] r_tab [4] = '{32'd8, 32'd6, 32'h0000_F000, 32'h0000_00FF};
  logic        bad_exp[4] = '{1'b0, 1'b0, 1'b0, 1'b0};

  wr_t q1[$];
  wr_t q2[$];
  int  acc1 = 0;
  int  acc2 = 0;

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] op);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // ---------------- DUT1: NVEC=4, base 0, checking on ----------------
  logic        start1 = 1'b0;
  logic        mem_ready1 = 1'b1;
  logic [1:0]  vec_idx1;
  logic [31:0] alu_porta1, alu_portb1, alu_out1, mem_addr1, mem_store1;
  logic [3:0]  alu_op1;
  logic        mem_wen1, busy1, halt1;
  logic [2:0]  err_count1;
  logic [1:0]  first_err1;

  assign alu_out1 = alu_f(alu_porta1, alu_portb1, alu_op1);

  alu_vector_sequencer #(.DW(32), .NVEC(4), .AW(32), .ADDR_BASE(32'h0000_0000),
                         .ADDR_STRIDE(4), .CHECK_EN(1)) dut1 (
    .CLK(CLK), .RST(RST), .start(start1), .vec_idx(vec_idx1),
    .vec_a(a_tab[vec_idx1]), .vec_b(b_tab[vec_idx1]), .vec_op(op_tab[vec_idx1]),
    .vec_exp(r_tab[vec_idx1] ^ {31'd0, bad_exp[vec_idx1]}), .vec_chk(1'b1),
    .alu_porta(alu_porta1), .alu_portb(alu_portb1), .alu_op(alu_op1), .alu_out(alu_out1),
    .mem_addr(mem_addr1), .mem_store(mem_store1), .mem_wen(mem_wen1), .mem_ready(mem_ready1),
    .busy(busy1), .halt(halt1), .err_count(err_count1), .first_err(first_err1));

  // ---------------- DUT2: wrapping base, checking off ----------------
  logic        start2 = 1'b0;
  logic [1:0]  vec_idx2;
  logic [31:0] alu_porta2, alu_portb2, alu_out2, mem_addr2, mem_store2;
  logic [3:0]  alu_op2;
  logic        mem_wen2, busy2, halt2;
  logic [2:0]  err_count2;
  logic [1:0]  first_err2;

  assign alu_out2 = alu_f(alu_porta2, alu_portb2, alu_op2);

  alu_vector_sequencer #(.DW(32), .NVEC(4), .AW(32), .ADDR_BASE(32'hFFFF_FFF8),
                         .ADDR_STRIDE(4), .CHECK_EN(0)) dut2 (
    .CLK(CLK), .RST(RST), .start(start2), .vec_idx(vec_idx2),
    .vec_a(a_tab[vec_idx2]), .vec_b(b_tab[vec_idx2]), .vec_op(op_tab[vec_idx2]),
    .vec_exp(r_tab[vec_idx2] ^ {31'd0, bad_exp[vec_idx2]}), .vec_chk(1'b1),
    .alu_porta(alu_porta2), .alu_portb(alu_portb2), .alu_op(alu_op2), .alu_out(alu_out2),
    .mem_addr(mem_addr2), .mem_store(mem_store2), .mem_wen(mem_wen2), .mem_ready(1'b1),
    .busy(busy2), .halt(halt2), .err_count(err_count2), .first_err(first_err2));

  // ---------------- DUT3: single-vector build ----------------
  logic        start3 = 1'b0;
  logic [0:0]  vec_idx3;
  logic [31:0] alu_porta3, alu_portb3, alu_out3, mem_addr3, mem_store3;
  logic [3:0]  alu_op3;
  logic        mem_wen3, busy3, halt3;
  logic [0:0]  err_count3;
  logic [0:0]  first_err3;

  assign alu_out3 = alu_f(alu_porta3, alu_portb3, alu_op3);

  alu_vector_sequencer #(.DW(32), .NVEC(1), .AW(32), .ADDR_BASE(32'h0000_0000),
                         .ADDR_STRIDE(4), .CHECK_EN(1)) dut3 (
    .CLK(CLK), .RST(RST), .start(start3), .vec_idx(vec_idx3),
    .vec_a(a_tab[{1'b0, vec_idx3}]), .vec_b(b_tab[{1'b0, vec_idx3}]),
    .vec_op(op_tab[{1'b0, vec_idx3}]),
    .vec_exp(r_tab[{1'b0, vec_idx3}] ^ {31'd0, bad_exp[{1'b0, vec_idx3}]}), .vec_chk(1'b1),
    .alu_porta(alu_porta3), .alu_portb(alu_portb3), .alu_op(alu_op3), .alu_out(alu_out3),
    .mem_addr(mem_addr3), .mem_store(mem_store3), .mem_wen(mem_wen3), .mem_ready(1'b1),
    .busy(busy3), .halt(halt3), .err_count(err_count3), .first_err(first_err3));

  // Write monitors: each accepted write must match the oldest queued expectation.
  always @(negedge CLK) begin
    wr_t e;
    if (mem_wen1 && mem_ready1) begin
      acc1++;
      chk("wr1_expected", 64'(q1.size() != 0), 64'd1);
      if (q1.size() != 0) begin
        e = q1.pop_front();
        chk("wr1_addr", 64'(mem_addr1), 64'(e.addr));
        chk("wr1_data", 64'(mem_store1), 64'(e.data));
      end
    end
    if (mem_wen2) begin
      acc2++;
      chk("wr2_expected", 64'(q2.size() != 0), 64'd1);
      if (q2.size() != 0) begin
        e = q2.pop_front();
        chk("wr2_addr", 64'(mem_addr2), 64'(e.addr));
        chk("wr2_data", 64'(mem_store2), 64'(e.data));
      end
    end
  end

  task automatic push_run1();
    for (int i = 0; i < 4; i++) q1.push_back('{addr: 32'(i * 4), data: r_tab[i]});
  endtask

  task automatic pulse_start1(input bit hold);
    start1 = 1'b1;
    @(posedge CLK); #1;
    if (!hold) start1 = 1'b0;
  endtask

  task automatic wait_halt1(output int n);
    n = 0;
    while (!halt1 && n < 200) begin
      @(posedge CLK); #1;
      n++;
    end
    start1 = 1'b0;
    chk("halt1_reached", 64'(halt1), 64'd1);
  endtask

  initial begin
    int n;
    int a0;
    bit stable;
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int n;
    int a0;
    bit stable;

    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_busy", 64'(busy1), 64'd0);
    chk("rst_halt", 64'(halt1), 64'd0);
    chk("rst_wen", 64'(mem_wen1), 64'd0);
    chk("rst_idx", 64'(vec_idx1), 64'd0);
    chk("rst_porta", 64'(alu_porta1), 64'd0);
    chk("rst_err", 64'(err_count1), 64'd0);
    chk("rst_addr2", 64'(mem_addr2), 64'd0);
    RST = 1'b0;
    @(posedge CLK); #1;

    // T1: clean run, 13 cycles to halt
    a0 = acc1;
    push_run1();
    pulse_start1(1'b0);
    wait_halt1(n);
    chk("t1_cycles", 64'(n + 1), 64'd13);
    chk("t1_err", 64'(err_count1), 64'd0);
    chk("t1_accepts", 64'(acc1 - a0), 64'd4);
    chk("t1_q_empty", 64'(q1.size()), 64'd0);

    // T2: wrong expects on vectors 1 and 3
    bad_exp[1] = 1'b1;
    bad_exp[3] = 1'b1;
    a0 = acc1;
    push_run1();
    pulse_start1(1'b0);
    wait_halt1(n);
    chk("t2_err", 64'(err_count1), 64'd2);
    chk("t2_first", 64'(first_err1), 64'd1);
    chk("t2_accepts", 64'(acc1 - a0), 64'd4);
    bad_exp[1] = 1'b0;
    bad_exp[3] = 1'b0;

    // T5: rerun from DONE with start held high through the run
    a0 = acc1;
    push_run1();
    pulse_start1(1'b1);
    wait_halt1(n);
    chk("t5_cycles", 64'(n + 1), 64'd13);
    chk("t5_err_cleared", 64'(err_count1), 64'd0);
    repeat (3) @(posedge CLK);
    #1;
    chk("t5_halt_held", 64'(halt1), 64'd1);
    chk("t5_not_busy", 64'(busy1), 64'd0);
    chk("t5_one_run", 64'(acc1 - a0), 64'd4);

    // T3: five stall cycles on vector 2
    a0 = acc1;
    push_run1();
    pulse_start1(1'b0);
    n = 0;
    while (!(mem_wen1 && vec_idx1 == 2'd2) && n < 50) begin
      @(posedge CLK); #1;
      n++;
    end
    mem_ready1 = 1'b0;
    chk("t3_addr", 64'(mem_addr1), 64'h8);
    chk("t3_data", 64'(mem_store1), 64'hF000);
    stable = 1'b1;
    repeat (5) begin
      @(posedge CLK); #1;
      if (!(mem_wen1 && mem_addr1 == 32'h8 && mem_store1 == 32'hF000)) stable = 1'b0;
    end
    chk("t3_stable", 64'(stable), 64'd1);
    chk("t3_accepts_stalled", 64'(acc1 - a0), 64'd2);
    mem_ready1 = 1'b1;
    @(posedge CLK); #1;
    chk("t3_idx_after_accept", 64'(vec_idx1), 64'd2);
    @(posedge CLK); #1;
    chk("t3_idx_advance", 64'(vec_idx1), 64'd3);
    wait_halt1(n);
    chk("t3_accepts", 64'(acc1 - a0), 64'd4);
    chk("t3_q_empty", 64'(q1.size()), 64'd0);

    // T4: reset in the second WRITE cycle of vector 1
    a0 = acc1;
    push_run1();
    pulse_start1(1'b0);
    n = 0;
    while (!(mem_wen1 && vec_idx1 == 2'd1) && n < 50) begin
      @(posedge CLK); #1;
      n++;
    end
    mem_ready1 = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    chk("t4_wen", 64'(mem_wen1), 64'd0);
    chk("t4_addr", 64'(mem_addr1), 64'd0);
    chk("t4_data", 64'(mem_store1), 64'd0);
    chk("t4_busy", 64'(busy1), 64'd0);
    chk("t4_idx", 64'(vec_idx1), 64'd0);
    chk("t4_accepts", 64'(acc1 - a0), 64'd1);
    q1.delete();
    RST = 1'b0;
    mem_ready1 = 1'b1;
    a0 = acc1;
    push_run1();
    pulse_start1(1'b0);
    wait_halt1(n);
    chk("t4_rerun_cycles", 64'(n + 1), 64'd13);
    chk("t4_rerun_accepts", 64'(acc1 - a0), 64'd4);

    // T6: wrapping addresses, checking disabled
    bad_exp[1] = 1'b1;
    bad_exp[3] = 1'b1;
    q2.push_back('{addr: 32'hFFFF_FFF8, data: r_tab[0]});
    q2.push_back('{addr: 32'hFFFF_FFFC, data: r_tab[1]});
    q2.push_back('{addr: 32'h0000_0000, data: r_tab[2]});
    q2.push_back('{addr: 32'h0000_0004, data: r_tab[3]});
    start2 = 1'b1;
    @(posedge CLK); #1;
    start2 = 1'b0;
    n = 0;
    while (!halt2 && n < 200) begin
      @(posedge CLK); #1;
      n++;
    end
    chk("t6_halt2", 64'(halt2), 64'd1);
    chk("t6_err_off", 64'(err_count2), 64'd0);
    chk("t6_accepts", 64'(acc2), 64'd4);
    bad_exp[1] = 1'b0;
    bad_exp[3] = 1'b0;

    // NVEC=1 build: halt 4 cycles after start, mismatch on the only vector
    bad_exp[0] = 1'b1;
    start3 = 1'b1;
    @(posedge CLK); #1;
    start3 = 1'b0;
    n = 0;
    while (!halt3 && n < 50) begin
      @(posedge CLK); #1;
      n++;
    end
    chk("nvec1_cycles", 64'(n + 1), 64'd4);
    chk("nvec1_err", 64'(err_count3), 64'd1);
    chk("nvec1_first", 64'(first_err3), 64'd0);
    bad_exp[0] = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
